// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared state encodings and default widths for the switch-driven memory loader
package mem_loader_pkg;
    localparam int LD_ADDR_W = 8;
    localparam int LD_DATA_W = 32;
    localparam int LD_BYTE_W = 8;
    typedef enum logic [1:0] {LD_IDLE, LD_COLLECT, LD_WRITE, LD_DONE} ld_state_t;
    function automatic int cnt_w(input int nb);
        return nb > 1 ? $clog2(nb) : 1;
    endfunction
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: operator inputs and memory write port of the loader; master is the loader side
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = LD_ADDR_W,
    parameter int DATA_W = LD_DATA_W,
    parameter int BYTE_W = LD_BYTE_W
);
    localparam int CW = cnt_w(DATA_W / BYTE_W);
    logic [BYTE_W-1:0] sw;
    logic              byte_stb;
    logic              addr_set;
    logic              wr_ack;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              loading;
    logic [CW-1:0]     byte_cnt;
    logic              err;
    logic [15:0]       disp;
    modport master (
        input  sw, byte_stb, addr_set, wr_ack,
        output wr_req, wr_addr, wr_data, loading, byte_cnt, err, disp
    );
    modport slave (
        output sw, byte_stb, addr_set, wr_ack,
        input  wr_req, wr_addr, wr_data, loading, byte_cnt, err, disp
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: packs switch bytes into words and writes them to memory at an auto-incrementing address
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W  = LD_ADDR_W,
    parameter int DATA_W  = LD_DATA_W,
    parameter int BYTE_W  = LD_BYTE_W,
    parameter int ACK_TMO = 15
) (
    input logic          clk,
    input logic          rst,
    mem_loader_if.master bus
);
    localparam int NB = DATA_W / BYTE_W;
    localparam int CW = cnt_w(NB);
    localparam int TW = $clog2(ACK_TMO + 1);

    ld_state_t         state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tmo;
    logic [BYTE_W-1:0] last;
    logic              err, set, take, full, timeout;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LD_IDLE;
        else     state <= state_n;

    // addr_set outranks a same-cycle byte; neither is honoured while a write is outstanding
    always_comb begin
        set     = bus.addr_set && state != LD_WRITE;
        take    = bus.byte_stb && !set && (state == LD_IDLE || state == LD_COLLECT);
        full    = take && cnt == CW'(NB - 1);
        timeout = state == LD_WRITE && !bus.wr_ack && tmo == TW'(ACK_TMO - 1);
        state_n = set ? LD_IDLE :
                  full ? LD_WRITE :
                  take ? LD_COLLECT :
                  (state == LD_WRITE && (bus.wr_ack || timeout)) ? LD_DONE :
                  state == LD_DONE ? LD_IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            data <= '0;
            cnt  <= '0;
            tmo  <= '0;
            last <= '0;
            err  <= 1'b0;
        end else begin
            tmo <= (state != LD_WRITE) ? '0 : (&tmo) ? tmo : tmo + TW'(1);
            if (set) begin
                addr <= ADDR_W'(bus.sw);
                data <= '0;
                cnt  <= '0;
                err  <= 1'b0;
            end else begin
                if (take) begin
                    data <= (data << BYTE_W) | DATA_W'(bus.sw);
                    cnt  <= full ? '0 : cnt + CW'(1);
                    last <= bus.sw;
                end
                if (timeout) err <= 1'b1;
                if (state == LD_DONE) addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign bus.wr_req   = state == LD_WRITE;
    assign bus.wr_addr  = addr;
    assign bus.wr_data  = data;
    assign bus.loading  = state == LD_COLLECT || state == LD_WRITE;
    assign bus.byte_cnt = cnt;
    assign bus.err      = err;
    assign bus.disp     = {8'(addr), 8'(last)};
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven word uploads plus hand-written corner sequences, scored against a write queue
module tb_mem_loader;
    localparam int TMO = 15;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0]  start;
        logic [31:0] word;
        int          dly;
        logic [7:0]  next;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   ack_dly = 0;
    int   rises = 0;
    wr_t  exp_q[$];
    vec_t tbl[3];

    mem_loader_if #(.ADDR_W(8), .DATA_W(32), .BYTE_W(8)) bus ();
    mem_loader #(.ADDR_W(8), .DATA_W(32), .BYTE_W(8), .ACK_TMO(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // memory model: acks once wr_req has been seen for more than ack_dly samples; ack_dly<0 never acks
    initial begin
        int n = 0;
        bus.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            n = bus.wr_req ? n + 1 : 0;
            bus.wr_ack = bus.wr_req && ack_dly >= 0 && n > ack_dly;
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_req && !prev) rises++;
            prev = bus.wr_req;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.sw = b;
        bus.byte_stb = 1'b1;
        tick();
        bus.byte_stb = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        bus.sw = a;
        bus.addr_set = 1'b1;
        tick();
        bus.addr_set = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    // pops the scoreboard when the DUT's request is acknowledged, then steps through DONE
    task automatic wait_write(input logic [7:0] next);
        bit  seen = 1'b0;
        wr_t e;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = bus.wr_req && bus.wr_ack;
        end
        check("write_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                check("wr_data", bus.wr_data, e.d);
            end
            tick();
            check("done_req", 32'(bus.wr_req), 32'd0);
            tick();
            check("next_addr", 32'(bus.wr_addr), 32'(next));
            check("idle_loading", 32'(bus.loading), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 32'(bus.wr_req), 32'd0);
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_data"}, bus.wr_data, 32'd0);
        check({tag, "_cnt"}, 32'(bus.byte_cnt), 32'd0);
        check({tag, "_loading"}, 32'(bus.loading), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_disp"}, 32'(bus.disp), 32'd0);
    endtask

    initial begin
        int hi;
        tbl[0] = '{start: 8'h10, word: 32'h12345678, dly: 2, next: 8'h11};
        tbl[1] = '{start: 8'hFF, word: 32'hDEADBEEF, dly: 0, next: 8'h00};
        tbl[2] = '{start: 8'h7F, word: 32'hA55A0FF0, dly: 5, next: 8'h80};
        bus.sw = '0;
        bus.byte_stb = 1'b0;
        bus.addr_set = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // full-word uploads, including the 0xFF -> 0x00 address wrap
        for (int v = 0; v < 3; v++) begin
            ack_dly = tbl[v].dly;
            set_addr(tbl[v].start);
            check("v_start", 32'(bus.wr_addr), 32'(tbl[v].start));
            for (int i = 0; i < 4; i++) begin
                send_byte(tbl[v].word[31-8*i -: 8]);
                check("v_cnt", 32'(bus.byte_cnt), 32'((i + 1) % 4));
                check("v_loading", 32'(bus.loading), 32'd1);
            end
            exp_q.push_back(wr_t'{tbl[v].start, tbl[v].word});
            check("v_req_latency", 32'(bus.wr_req), 32'd1);
            check("v_disp", 32'(bus.disp), 32'({tbl[v].start, tbl[v].word[7:0]}));
            wait_write(tbl[v].next);
        end

        // no ack: request times out after TMO cycles, err sticks until addr_set
        ack_dly = -1;
        set_addr(8'h20);
        send_word(32'hCAFEF00D);
        hi = 0;
        while (bus.wr_req && hi < 40) begin
            hi++;
            tick();
        end
        check("tmo_req_cycles", 32'(hi), 32'(TMO));
        check("tmo_err", 32'(bus.err), 32'd1);
        tick();
        check("tmo_next_addr", 32'(bus.wr_addr), 32'h21);
        check("tmo_loading", 32'(bus.loading), 32'd0);
        check("tmo_err_sticky", 32'(bus.err), 32'd1);
        set_addr(8'h30);
        check("err_cleared", 32'(bus.err), 32'd0);
        check("err_clr_addr", 32'(bus.wr_addr), 32'h30);

        // addr_set in mid-word discards the partial word
        ack_dly = 1;
        set_addr(8'h50);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("part_cnt", 32'(bus.byte_cnt), 32'd2);
        check("part_loading", 32'(bus.loading), 32'd1);
        set_addr(8'h40);
        check("abort_cnt", 32'(bus.byte_cnt), 32'd0);
        check("abort_loading", 32'(bus.loading), 32'd0);
        check("abort_addr", 32'(bus.wr_addr), 32'h40);
        send_word(32'h11223344);
        exp_q.push_back(wr_t'{8'h40, 32'h11223344});
        wait_write(8'h41);

        // simultaneous byte+addr_set drops the byte; byte and addr_set during WRITE are ignored
        ack_dly = 5;
        bus.sw = 8'h60;
        bus.byte_stb = 1'b1;
        bus.addr_set = 1'b1;
        tick();
        bus.byte_stb = 1'b0;
        bus.addr_set = 1'b0;
        check("both_cnt", 32'(bus.byte_cnt), 32'd0);
        check("both_loading", 32'(bus.loading), 32'd0);
        check("both_disp", 32'(bus.disp), 32'h6044);
        send_word(32'h01020304);
        exp_q.push_back(wr_t'{8'h60, 32'h01020304});
        check("w5_req", 32'(bus.wr_req), 32'd1);
        send_byte(8'hEE);
        check("wr_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        check("wr_byte_disp", 32'(bus.disp), 32'h6004);
        check("wr_byte_data", bus.wr_data, 32'h01020304);
        set_addr(8'h99);
        check("wr_set_addr", 32'(bus.wr_addr), 32'h60);
        wait_write(8'h61);

        // asynchronous reset while a write is pending
        ack_dly = -1;
        send_word(32'h55667788);
        tick();
        check("pre_rst_req", 32'(bus.wr_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_req", 32'(bus.wr_req), 32'd0);

        check("req_rises", 32'(rises), 32'd7);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
